// File: rtl/ew_pattern_gen_pkg.sv
// ew_pattern_gen_pkg: shared tracker constants for the pattern generator.
// These are the tracker parameters the generator and any pattern checker
// share.
//   DIGI_BITS         : EW FIFO data word width (32)
//   EVENT_SIZE_BITS   : width of the window-size field (64-bit beats)
//   SPILL_TAG_BITS    : width of the window tag
//   PATTERN_PAD_WORD  : filler word that rounds odd windows up to a full beat
//   PATTERN_LFSR_SEED : PRBS payload seed loaded at run start
//   pg_state_e        : generator state encoding (shared with checkers)
package ew_pattern_gen_pkg;

  localparam int DIGI_BITS       = 32;
  localparam int EVENT_SIZE_BITS = 10;
  localparam int SPILL_TAG_BITS  = 8;

  localparam logic [DIGI_BITS-1:0] PATTERN_PAD_WORD  = 32'hFFFF_FFFF;
  localparam logic [15:0]          PATTERN_LFSR_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_PAD   = 3'd3,
    ST_DONE  = 3'd4,
    ST_GAP   = 3'd5
  } pg_state_e;

  // Window size in 64-bit beats: ceil(n / 2).
  function automatic logic [EVENT_SIZE_BITS-1:0] beats_of(input logic [7:0] n);
    return EVENT_SIZE_BITS'((9'(n) + 9'd1) >> 1);
  endfunction

endpackage

// File: rtl/ew_pattern_gen_if.sv
// ew_pattern_gen_if: event-window FIFO write bus between the pattern source
// (master) and the DIGI/pattern selector / EW FIFO controller (slave).
//   curr_ewfifo_wr : ping-pong EW FIFO select
//   ew_fifo_we     : data write strobe
//   ew_fifo_data   : data word
//   ew_done        : one-cycle end-of-window pulse
//   ew_ovfl        : window was truncated (valid with ew_done)
//   ew_size        : window size in 64-bit beats (valid with ew_done)
//   ew_tag         : window tag (valid with ew_done)
interface ew_pattern_gen_if;
  import ew_pattern_gen_pkg::*;

  logic                       curr_ewfifo_wr;
  logic                       ew_fifo_we;
  logic [DIGI_BITS-1:0]       ew_fifo_data;
  logic                       ew_done;
  logic                       ew_ovfl;
  logic [EVENT_SIZE_BITS-1:0] ew_size;
  logic [SPILL_TAG_BITS-1:0]  ew_tag;

  modport master (
    output curr_ewfifo_wr, ew_fifo_we, ew_fifo_data,
    output ew_done, ew_ovfl, ew_size, ew_tag
  );

  modport slave (
    input curr_ewfifo_wr, ew_fifo_we, ew_fifo_data,
    input ew_done, ew_ovfl, ew_size, ew_tag
  );

endinterface

// File: rtl/pattern_lfsr16.sv
// pattern_lfsr16: 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1.
//   clk, resetn : clock, asynchronous active-low reset
//   load        : reload PATTERN_LFSR_SEED (has priority over advance)
//   advance     : step the sequence by one
//   q           : current value
module pattern_lfsr16
  import ew_pattern_gen_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic        advance,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q <= '0;
    end else if (load) begin
      q <= PATTERN_LFSR_SEED;
    end else if (advance) begin
      q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    end
  end

endmodule

// File: rtl/ew_pattern_gen.sv
// ew_pattern_gen: synthetic event-window source for the tracker ROC readout.
// Emits windows of {tag[7:0], word_idx[7:0], payload[15:0]} words in the EW
// FIFO write format, padding odd windows to whole 64-bit beats, and
// ping-pongs the current EW FIFO between windows.
// Optional feature macro: PATTERN_PRBS_EN (payload from pattern_lfsr16
// instead of an incrementing counter).
//   serdesclk, serdes_resetn : clock, asynchronous active-low reset
//   axi_start_on_serdesclk   : run-start pulse (honoured in IDLE only)
//   pattern_stop             : finish the current window, then go idle
//   cfg_hits_per_ew          : words per window (capped at MAX_WORDS)
//   cfg_num_ew               : windows per run, 0 = free-run
//   cfg_ew_gap               : idle cycles between windows
//   ew                       : EW FIFO write bus (master)
//   busy                     : run in progress
module ew_pattern_gen
  import ew_pattern_gen_pkg::*;
#(
  parameter int MAX_WORDS = 64
) (
  input  logic                      serdesclk,
  input  logic                      serdes_resetn,
  input  logic                      axi_start_on_serdesclk,
  input  logic                      pattern_stop,
  input  logic [7:0]                cfg_hits_per_ew,
  input  logic [SPILL_TAG_BITS-1:0] cfg_num_ew,
  input  logic [15:0]               cfg_ew_gap,
  ew_pattern_gen_if.master          ew,
  output logic                      busy
);

  localparam logic [SPILL_TAG_BITS-1:0] TAG_ONE = SPILL_TAG_BITS'(1);
  localparam logic [7:0]                MAX_N   = 8'(MAX_WORDS);

  pg_state_e                 state, state_next;
  logic [7:0]                n_r, idx;
  logic                      ovfl_r, sel;
  logic [SPILL_TAG_BITS-1:0] tag, win_cnt;
  logic [15:0]               gap_cnt, payload_q;
  logic                      start_acc, last_win, gap_end;
  logic [7:0]                n_load;

  assign start_acc = (state == ST_IDLE) && axi_start_on_serdesclk;
  assign n_load    = (cfg_hits_per_ew > MAX_N) ? MAX_N : cfg_hits_per_ew;
  assign last_win  = pattern_stop ||
                     ((cfg_num_ew != '0) && ((win_cnt + TAG_ONE) == cfg_num_ew));
  // >= rather than == so a gap shortened mid-wait cannot strand the FSM.
  assign gap_end   = ({1'b0, gap_cnt} + 17'd1) >= {1'b0, cfg_ew_gap};

  always_ff @(posedge serdesclk or negedge serdes_resetn) begin
    if (!serdes_resetn) state <= ST_IDLE;
    else                state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (axi_start_on_serdesclk) state_next = ST_LOAD;
      ST_LOAD:  state_next = (n_load == 8'd0) ? ST_DONE : ST_WRITE;
      ST_WRITE: if (idx == n_r - 8'd1) state_next = n_r[0] ? ST_PAD : ST_DONE;
      ST_PAD:   state_next = ST_DONE;
      ST_DONE: begin
        if (last_win)                state_next = ST_IDLE;
        else if (cfg_ew_gap == 16'd0) state_next = ST_LOAD;
        else                          state_next = ST_GAP;
      end
      ST_GAP:   if (gap_end) state_next = ST_LOAD;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Run and window bookkeeping.
  always_ff @(posedge serdesclk or negedge serdes_resetn) begin
    if (!serdes_resetn) begin
      n_r     <= '0;
      ovfl_r  <= 1'b0;
      idx     <= '0;
      tag     <= '0;
      win_cnt <= '0;
      sel     <= 1'b0;
      gap_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start_acc) begin
          tag     <= TAG_ONE;
          win_cnt <= '0;
          sel     <= 1'b0;
        end
        ST_LOAD: begin
          n_r    <= n_load;
          ovfl_r <= (cfg_hits_per_ew > MAX_N);
          idx    <= '0;
        end
        ST_WRITE: idx <= idx + 8'd1;
        ST_DONE: if (!last_win) begin
          sel     <= ~sel;
          tag     <= tag + TAG_ONE;
          win_cnt <= win_cnt + TAG_ONE;
          gap_cnt <= '0;
        end
        ST_GAP: gap_cnt <= gap_cnt + 16'd1;
        default: ;
      endcase
    end
  end

`ifdef PATTERN_PRBS_EN
  pattern_lfsr16 u_lfsr (
    .clk     (serdesclk),
    .resetn  (serdes_resetn),
    .load    (start_acc),
    .advance (state == ST_WRITE),
    .q       (payload_q)
  );
`else
  // Payload runs on across windows; only a new run clears it.
  always_ff @(posedge serdesclk or negedge serdes_resetn) begin
    if (!serdes_resetn)          payload_q <= '0;
    else if (start_acc)          payload_q <= '0;
    else if (state == ST_WRITE)  payload_q <= payload_q + 16'd1;
  end
`endif

  // Output register stage: bus reflects the state of the previous cycle.
  always_ff @(posedge serdesclk or negedge serdes_resetn) begin
    if (!serdes_resetn) begin
      ew.ew_fifo_we     <= 1'b0;
      ew.ew_fifo_data   <= '0;
      ew.ew_done        <= 1'b0;
      ew.ew_ovfl        <= 1'b0;
      ew.ew_size        <= '0;
      ew.ew_tag         <= '0;
      ew.curr_ewfifo_wr <= 1'b0;
      busy              <= 1'b0;
    end else begin
      ew.ew_fifo_we     <= (state == ST_WRITE) || (state == ST_PAD);
      ew.ew_done        <= (state == ST_DONE);
      ew.curr_ewfifo_wr <= sel;
      busy              <= (state != ST_IDLE) || (state_next != ST_IDLE);
      if (state == ST_WRITE) ew.ew_fifo_data <= {tag[7:0], idx, payload_q};
      else if (state == ST_PAD) ew.ew_fifo_data <= PATTERN_PAD_WORD;
      if (state == ST_DONE) begin
        ew.ew_size <= beats_of(n_r);
        ew.ew_tag  <= tag;
        ew.ew_ovfl <= ovfl_r;
      end
    end
  end

endmodule

// File: tb/tb_ew_pattern_gen.sv
// tb_ew_pattern_gen: directed bench for ew_pattern_gen (default build,
// incrementing payload). A negedge logger captures every write and every
// end-of-window pulse; each scenario then compares the log against
// hand-computed words and window descriptors.
module tb_ew_pattern_gen;
  import ew_pattern_gen_pkg::*;

  logic        serdesclk = 1'b0;
  logic        serdes_resetn = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [7:0]  cfg_hits = 8'd0;
  logic [7:0]  cfg_num = 8'd1;
  logic [15:0] cfg_gap = 16'd0;
  logic        busy;

  ew_pattern_gen_if ew ();

  ew_pattern_gen #(.MAX_WORDS(64)) dut (
    .serdesclk              (serdesclk),
    .serdes_resetn          (serdes_resetn),
    .axi_start_on_serdesclk (start),
    .pattern_stop           (stop),
    .cfg_hits_per_ew        (cfg_hits),
    .cfg_num_ew             (cfg_num),
    .cfg_ew_gap             (cfg_gap),
    .ew                     (ew),
    .busy                   (busy)
  );

  always #5 serdesclk = ~serdesclk;

  typedef struct {
    int size;
    int tag;
    int ovfl;
    int sel;
    int bsy;
    int cyc;
  } done_t;

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] wr_d[$];
  logic        wr_s[$];
  int          wr_c[$];
  done_t       dn_q[$];
  int          fall_cyc = -1;
  logic        busy_prev = 1'b0;

  always @(posedge serdesclk) cyc <= cyc + 1;

  always @(negedge serdesclk) begin
    if (ew.ew_fifo_we) begin
      wr_d.push_back(ew.ew_fifo_data);
      wr_s.push_back(ew.curr_ewfifo_wr);
      wr_c.push_back(cyc);
    end
    if (ew.ew_done)
      dn_q.push_back('{size: int'(ew.ew_size), tag: int'(ew.ew_tag),
                       ovfl: int'(ew.ew_ovfl), sel: int'(ew.curr_ewfifo_wr),
                       bsy: int'(busy), cyc: cyc});
    if (busy_prev && !busy) fall_cyc = cyc;
    busy_prev = busy;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] wr_at(input int i);
    return (i < wr_d.size()) ? wr_d[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic int wsel_at(input int i);
    return (i < wr_s.size()) ? int'(wr_s[i]) : -1;
  endfunction

  function automatic done_t dn_at(input int i);
    done_t d;
    d = '{size: -1, tag: -1, ovfl: -1, sel: -1, bsy: -1, cyc: -1};
    if (i < dn_q.size()) d = dn_q[i];
    return d;
  endfunction

  task automatic clear_log();
    wr_d.delete();
    wr_s.delete();
    wr_c.delete();
    dn_q.delete();
    fall_cyc = -1;
  endtask

  // Called at a negedge; start is high across exactly one posedge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge serdesclk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge serdesclk);
      k++;
    end
    if (busy) check_eq("idle_timeout", 32'(busy), 32'd0);
    repeat (3) @(negedge serdesclk);
  endtask

  task automatic wait_writes(input int n, input int budget);
    int k = 0;
    while (wr_d.size() < n && k < budget) begin
      @(negedge serdesclk);
      k++;
    end
    if (wr_d.size() < n) check_eq("wr_timeout", 32'(wr_d.size()), 32'(n));
  endtask

  task automatic check_done(input string nm, input int i, input int size,
                            input int tag, input int ovfl, input int sel);
    done_t d;
    d = dn_at(i);
    check_eq({nm, "_size"}, 32'(d.size), 32'(size));
    check_eq({nm, "_tag"},  32'(d.tag),  32'(tag));
    check_eq({nm, "_ovfl"}, 32'(d.ovfl), 32'(ovfl));
    check_eq({nm, "_sel"},  32'(d.sel),  32'(sel));
  endtask

  initial begin
    logic [31:0] exp_w[$];

    // Reset values
    repeat (3) @(negedge serdesclk);
    check_eq("rst_we",   32'(ew.ew_fifo_we), 32'd0);
    check_eq("rst_data", ew.ew_fifo_data, 32'd0);
    check_eq("rst_done", 32'(ew.ew_done), 32'd0);
    check_eq("rst_size", 32'(ew.ew_size), 32'd0);
    check_eq("rst_tag",  32'(ew.ew_tag), 32'd0);
    check_eq("rst_ovfl", 32'(ew.ew_ovfl), 32'd0);
    check_eq("rst_sel",  32'(ew.curr_ewfifo_wr), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    serdes_resetn = 1'b1;
    repeat (2) @(negedge serdesclk);

    // Basic run with start-to-first-write latency
    cfg_hits = 8'd4; cfg_num = 8'd1; cfg_gap = 16'd0;
    clear_log();
    pulse_start();
    check_eq("lat_e0_we", 32'(ew.ew_fifo_we), 32'd0);
    check_eq("lat_e0_busy", 32'(busy), 32'd1);
    @(negedge serdesclk);
    check_eq("lat_e1_we", 32'(ew.ew_fifo_we), 32'd0);
    @(negedge serdesclk);
    check_eq("lat_e2_we", 32'(ew.ew_fifo_we), 32'd1);
    wait_idle(200);
    exp_w = '{32'h0100_0000, 32'h0101_0001, 32'h0102_0002, 32'h0103_0003};
    check_eq("basic_nwr", 32'(wr_d.size()), 32'd4);
    foreach (exp_w[i]) check_eq($sformatf("basic_w%0d", i), wr_at(i), exp_w[i]);
    check_eq("basic_ndone", 32'(dn_q.size()), 32'd1);
    check_done("basic", 0, 2, 1, 0, 0);
    check_eq("basic_done_lat", 32'(dn_at(0).cyc - ((wr_c.size() > 3) ? wr_c[3] : -9)), 32'd1);
    check_eq("basic_busy_at_done", 32'(dn_at(0).bsy), 32'd1);
    check_eq("basic_busy_fall", 32'(fall_cyc), 32'(dn_at(0).cyc + 1));

    // Odd count gets a pad word
    cfg_hits = 8'd3;
    clear_log();
    pulse_start();
    wait_idle(200);
    exp_w = '{32'h0100_0000, 32'h0101_0001, 32'h0102_0002, 32'hFFFF_FFFF};
    check_eq("odd_nwr", 32'(wr_d.size()), 32'd4);
    foreach (exp_w[i]) check_eq($sformatf("odd_w%0d", i), wr_at(i), exp_w[i]);
    check_done("odd", 0, 2, 1, 0, 0);

    // Overflow truncates to MAX_WORDS
    cfg_hits = 8'd100;
    clear_log();
    pulse_start();
    wait_idle(400);
    check_eq("ovf_nwr", 32'(wr_d.size()), 32'd64);
    check_eq("ovf_w0", wr_at(0), 32'h0100_0000);
    check_eq("ovf_w63", wr_at(63), 32'h013F_003F);
    check_eq("ovf_ndone", 32'(dn_q.size()), 32'd1);
    check_done("ovf", 0, 32, 1, 1, 0);

    // Multi-window run with gap and ping-pong
    cfg_hits = 8'd2; cfg_num = 8'd3; cfg_gap = 16'd5;
    clear_log();
    pulse_start();
    wait_idle(400);
    exp_w = '{32'h0100_0000, 32'h0101_0001, 32'h0200_0002,
              32'h0201_0003, 32'h0300_0004, 32'h0301_0005};
    check_eq("multi_nwr", 32'(wr_d.size()), 32'd6);
    foreach (exp_w[i]) begin
      check_eq($sformatf("multi_w%0d", i), wr_at(i), exp_w[i]);
      check_eq($sformatf("multi_wsel%0d", i), 32'(wsel_at(i)), 32'((i / 2) % 2));
    end
    check_eq("multi_ndone", 32'(dn_q.size()), 32'd3);
    check_done("multi0", 0, 1, 1, 0, 0);
    check_done("multi1", 1, 1, 2, 0, 1);
    check_done("multi2", 2, 1, 3, 0, 0);
    check_eq("multi_between01", 32'(dn_at(1).cyc - dn_at(0).cyc - 1), 32'd8);
    check_eq("multi_between12", 32'(dn_at(2).cyc - dn_at(1).cyc - 1), 32'd8);

    // Zero hits: descriptor only
    cfg_hits = 8'd0; cfg_num = 8'd1; cfg_gap = 16'd0;
    clear_log();
    pulse_start();
    wait_idle(200);
    check_eq("zero_nwr", 32'(wr_d.size()), 32'd0);
    check_eq("zero_ndone", 32'(dn_q.size()), 32'd1);
    check_done("zero", 0, 0, 1, 0, 0);

    // Free-run stopped mid-window; a start pulse while busy is ignored
    cfg_hits = 8'd4; cfg_num = 8'd0; cfg_gap = 16'd3;
    clear_log();
    pulse_start();
    wait_writes(2, 50);
    start = 1'b1;
    stop = 1'b1;
    @(negedge serdesclk);
    start = 1'b0;
    wait_idle(200);
    stop = 1'b0;
    exp_w = '{32'h0100_0000, 32'h0101_0001, 32'h0102_0002, 32'h0103_0003};
    check_eq("stop_nwr", 32'(wr_d.size()), 32'd4);
    foreach (exp_w[i]) check_eq($sformatf("stop_w%0d", i), wr_at(i), exp_w[i]);
    check_eq("stop_ndone", 32'(dn_q.size()), 32'd1);
    check_done("stop", 0, 2, 1, 0, 0);
    check_eq("stop_busy_fall", 32'(fall_cyc), 32'(dn_at(0).cyc + 1));

    // Reset in WRITE, then a fresh run
    cfg_hits = 8'd8; cfg_num = 8'd1; cfg_gap = 16'd0;
    clear_log();
    pulse_start();
    wait_writes(3, 50);
    #2 serdes_resetn = 1'b0;
    #1;
    check_eq("mrst_we",   32'(ew.ew_fifo_we), 32'd0);
    check_eq("mrst_data", ew.ew_fifo_data, 32'd0);
    check_eq("mrst_busy", 32'(busy), 32'd0);
    check_eq("mrst_tag",  32'(ew.ew_tag), 32'd0);
    check_eq("mrst_size", 32'(ew.ew_size), 32'd0);
    repeat (2) @(negedge serdesclk);
    serdes_resetn = 1'b1;
    repeat (5) @(negedge serdesclk);
    check_eq("mrst_ndone", 32'(dn_q.size()), 32'd0);
    cfg_hits = 8'd2;
    clear_log();
    pulse_start();
    wait_idle(200);
    check_eq("rerun_w0", wr_at(0), 32'h0100_0000);
    check_eq("rerun_w1", wr_at(1), 32'h0101_0001);
    check_done("rerun", 0, 1, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ew_pattern_gen.md
# ew_pattern_gen

Synthetic event-window source for the tracker ROC readout path. It generates deterministic hit data in the event-window FIFO write format and drives the pattern-side inputs of the DIGI/pattern selector (`PATTRN_*`), so the downstream EW FIFO controller and DDR path can be exercised without DIGI front-ends. A run starts on the pattern-gated `axi_start_on_serdesclk` pulse and emits a configurable number of windows, ping-ponging the current EW FIFO.

## Interface
- `MAX_WORDS`, 64: per-window word cap. A larger request is truncated and flagged as overflow.
- `serdesclk` in 1: the single clock for the block.
- `serdes_resetn` in 1: reset, asynchronous assert, active-low.
- `axi_start_on_serdesclk` in 1: one-cycle run-start pulse. Tie to `PATTRN_axi_start_on_serdesclk`.
- `pattern_stop` in 1: level input. The block finishes the current window, then goes idle.
- `cfg_hits_per_ew` in 8: words per window, in units of 32-bit `DIGI_BITS` words.
- `cfg_num_ew` in `SPILL_TAG_BITS`: windows per run. A value of 0 means free-run until `pattern_stop`.
- `cfg_ew_gap` in 16: idle cycles between windows.
- `curr_ewfifo_wr` out 1: selects the ping-pong EW FIFO.
- `ew_fifo_we` out 1: data write strobe.
- `ew_fifo_data` out `DIGI_BITS`: data word.
- `ew_done` out 1: one-cycle end-of-window pulse.
- `ew_ovfl` out 1: window was truncated. Valid with `ew_done`.
- `ew_size` out `EVENT_SIZE_BITS`: window size in 64-bit beats. Valid with `ew_done`.
- `ew_tag` out `SPILL_TAG_BITS`: window tag. Valid with `ew_done`.
- `busy` out 1: high from accepted start until return to IDLE.

## Operation
- States: IDLE, LOAD, WRITE, PAD, DONE, GAP.
- IDLE: on `axi_start_on_serdesclk`, go to LOAD.
  - Tag counter loads 1. This matches the 1-based DIGI tags after the selector's +1.
  - `curr_ewfifo_wr` is set to 0.
  - Payload counter clears.
- LOAD: samples `cfg_hits_per_ew`.
  - `n = min(cfg, MAX_WORDS)`.
  - `ovfl_r = (cfg > MAX_WORDS)`.
  - If `n == 0`, go to DONE; otherwise go to WRITE.
- WRITE: `ew_fifo_we = 1` every cycle for `n` cycles.
  - Data word: `{tag[7:0], word_idx[7:0], payload[15:0]}`.
  - `payload` increments by 1 per word and persists across windows within a run.
  - After the last word: if `n` is odd, go to PAD; otherwise go to DONE.
- PAD: one write of filler `32'hFFFF_FFFF`, so every window is whole 64-bit beats. Then go to DONE.
- DONE: `ew_done = 1` for one cycle.
  - `ew_size = ceil(n/2)`.
  - `ew_tag` = current tag.
  - `ew_ovfl = ovfl_r`.
- Leaving DONE:
  - Go to IDLE if `pattern_stop`, or if `cfg_num_ew != 0` and the windows emitted equal `cfg_num_ew`.
  - Otherwise toggle `curr_ewfifo_wr`, increment the tag (wraps modulo 2^`SPILL_TAG_BITS`) and go to GAP.
- GAP: wait `cfg_ew_gap` cycles, then go to LOAD. With `cfg_ew_gap == 0`, go to LOAD on the next cycle.
- Start pulses outside IDLE are ignored.
- `pattern_stop` asserted in IDLE has no effect.
- Reset mid-window: all outputs return to reset values immediately. No `ew_done` is issued for the partial window.

## Timing
- All outputs are registered.
- Reset values: every output is 0, including `curr_ewfifo_wr`, `ew_size`, `ew_tag` and `busy`.
- Latency: start sampled at edge 0 → LOAD at edge 1 → first `ew_fifo_we` visible after edge 2.
- `ew_done` rises the cycle after the last write (data or pad).
- `ew_size`, `ew_tag` and `ew_ovfl` are updated in the DONE cycle and held until the next DONE.
- `curr_ewfifo_wr` toggles on the cycle after `ew_done`. It never changes while `ew_fifo_we` is high.
- Window period in cycles: `1 (LOAD) + n + (n odd) + 1 (DONE) + cfg_ew_gap`.
- There is no back-pressure. The downstream FIFO is sized for `MAX_WORDS`+1 words.

## Configuration
- `PATTERN_PRBS_EN` defined: `payload[15:0]` comes from a 16-bit Fibonacci LFSR.
  - Polynomial x^16+x^14+x^13+x^11+1.
  - Seeded to 16'hACE1 at run start.
  - Advances once per data word; pad words do not advance it.
- `PATTERN_PRBS_EN` undefined: `payload` is the incrementing counter. The LFSR logic is absent.

## Structure
- Shared constants `DIGI_BITS` (32), `EVENT_SIZE_BITS` and `SPILL_TAG_BITS` come from `tracker_params.vh`.
- Add to `tracker_params.vh`:
  - `PATTERN_PAD_WORD`.
  - `PATTERN_LFSR_SEED`.
  - The state encoding localparams shared with any pattern checker.
- One sub-module, `pattern_lfsr16`, with ports clk, resetn, load, advance, q[15:0]. It is instantiated only under `PATTERN_PRBS_EN`.

## Test plan
- Basic run: `cfg_hits=4`, `num_ew=1`, gap 0, start.
  - Data 0x0100_0000, 0x0101_0001, 0x0102_0002, 0x0103_0003.
  - Then `ew_done` with `ew_size=2`, `ew_tag=1`, `ew_ovfl=0`, `curr_ewfifo_wr=0`.
- Odd count: `cfg_hits=3`.
  - Three data words, then 0xFFFF_FFFF.
  - `ew_size=2`.
- Overflow: `cfg_hits=100`, `MAX_WORDS=64`.
  - Exactly 64 writes.
  - `ew_size=32`, `ew_ovfl=1`.
- Multi-window: `num_ew=3`, gap=5, `cfg_hits=2`.
  - Tags 1, 2, 3.
  - `curr_ewfifo_wr` is 0, 1, 0.
  - 8 cycles between `ew_done` pulses.
  - Payload continues 0–5.
- Zero hits, stop and ignored start:
  - `cfg_hits=0` → `ew_done` with `ew_size=0` and no writes.
  - `pattern_stop` mid-window in free-run → current window completes, `busy` drops after DONE.
  - A start pulse while busy is ignored.
- Reset in WRITE:
  - Outputs clear within the reset-assertion cycle.
  - No `ew_done` is issued.
  - A new start begins again at tag 1.
